// File: rtl/gray_ctrl_pkg.sv
// Shared types for the Gray counter button sequencer.
package gray_ctrl_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stable-sample debounce counter and
// a registered one-cycle pulse on every debounced rising edge.
module btn_debounce
  import gray_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int CW         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   smp;

  assign smp = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      press <= 1'b0;
      if (smp == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // DEB_CYCLES-th consecutive differing sample: accept the new level
        cnt   <= '0;
        level <= smp;
        press <= smp;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/gray_step_controller.sv
// Button-driven step/run/clear sequencer for the Gray counter.
// Optional step auto-repeat is built when GRAY_CTRL_AUTOREPEAT_EN is defined.
module gray_step_controller
  import gray_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = 50000,
  parameter int RUN_DIV     = 5000000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int CW          = 26
) (
  input  logic clk_input,
  input  logic rst,
  input  logic btn_step,
  input  logic btn_run,
  input  logic btn_clr,
  output logic cnt_en,
  output logic cnt_rst,
  output logic run_active
);
  // bit 0 = step, bit 1 = run, bit 2 = clear
  logic [2:0] btn_raw, lvl, prs;
  logic       unused_lvl;

  assign btn_raw    = {btn_clr, btn_run, btn_step};
  assign unused_lvl = ^lvl;

  for (genvar b = 0; b < 3; b++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_deb (
      .clk  (clk_input),
      .rst  (rst),
      .btn  (btn_raw[b]),
      .level(lvl[b]),
      .press(prs[b])
    );
  end

  state_t        state, state_nxt;
  logic [CW-1:0] presc, presc_nxt;
  logic          en_nxt, rst_nxt;

`ifdef GRAY_CTRL_AUTOREPEAT_EN
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic          hold_act, hold_act_nxt, hold_rep, hold_rep_nxt, hold_fire;

  // first repeat after HOLD_CYCLES, then one every RUN_DIV
  assign hold_fire = hold_rep ? (hold_cnt == CW'(RUN_DIV - 1))
                              : (hold_cnt == CW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk_input) begin
    if (rst) begin
      hold_cnt <= '0;
      hold_act <= 1'b0;
      hold_rep <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
      hold_act <= hold_act_nxt;
      hold_rep <= hold_rep_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    presc_nxt = '0;
    en_nxt    = 1'b0;
    rst_nxt   = 1'b0;
`ifdef GRAY_CTRL_AUTOREPEAT_EN
    hold_act_nxt = 1'b0;
    hold_rep_nxt = 1'b0;
    hold_cnt_nxt = '0;
`endif
    if (prs[2]) begin
      rst_nxt   = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (prs[1]) begin
            state_nxt = RUN;
          end else if (prs[0]) begin
            en_nxt = 1'b1;
`ifdef GRAY_CTRL_AUTOREPEAT_EN
            hold_act_nxt = 1'b1;
          end else if (hold_act && lvl[0]) begin
            hold_act_nxt = 1'b1;
            if (hold_fire) begin
              en_nxt       = 1'b1;
              hold_rep_nxt = 1'b1;
            end else begin
              hold_cnt_nxt = hold_cnt + 1'b1;
              hold_rep_nxt = hold_rep;
            end
`endif
          end
        end
        RUN: begin
          // a stop press also swallows a pulse that was due this cycle
          if (prs[1]) begin
            state_nxt = IDLE;
          end else begin
            en_nxt    = (presc == CW'(RUN_DIV - 1));
            presc_nxt = en_nxt ? '0 : presc + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_input) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      cnt_en     <= 1'b0;
      cnt_rst    <= 1'b0;
      run_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      cnt_en     <= en_nxt;
      cnt_rst    <= rst_nxt;
      run_active <= (state_nxt == RUN);
    end
  end
endmodule

// File: tb/tb_gray_step_controller.sv
// Randomised and directed bench for gray_step_controller against a
// cycle-level behavioural model of the button rules.
module tb_gray_step_controller;
  localparam int DEB = 4, RDIV = 8, HOLD = 16, CW = 8;
`ifdef GRAY_CTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, btn_step = 1'b0, btn_run = 1'b0, btn_clr = 1'b0;
  logic cnt_en, cnt_rst, run_active;
  int   n_pass = 0, n_total = 0;

  gray_step_controller #(.DEB_CYCLES(DEB), .RUN_DIV(RDIV), .HOLD_CYCLES(HOLD), .CW(CW)) dut (
    .clk_input(clk), .rst(rst), .btn_step(btn_step), .btn_run(btn_run), .btn_clr(btn_clr),
    .cnt_en(cnt_en), .cnt_rst(cnt_rst), .run_active(run_active));

  always #5 clk = ~clk;

  // model: raw->sample delay line, debounced level, run length of differing samples
  bit r1[3], r2[3], lvl[3], prs[3];
  int run_len[3];
  bit m_run, h_act, m_en, m_rst, m_act;
  int m_since, h_since;

  task automatic tick(input bit st, input bit ru, input bit cl, input bit rs);
    bit raw[3];
    bit n_en, n_rst, s;
    @(negedge clk);
    btn_step = st; btn_run = ru; btn_clr = cl; rst = rs;
    @(posedge clk);
    raw = '{st, ru, cl};
    if (rs) begin
      for (int b = 0; b < 3; b++) begin
        r1[b] = 0; r2[b] = 0; lvl[b] = 0; prs[b] = 0; run_len[b] = 0;
      end
      m_run = 0; h_act = 0; m_since = 0; h_since = 0;
      m_en = 0; m_rst = 0; m_act = 0;
    end else begin
      n_en = 0; n_rst = 0;
      if (prs[2]) begin
        n_rst = 1; m_run = 0; h_act = 0;
      end else if (m_run) begin
        if (prs[1]) m_run = 0;
        else begin
          m_since++;
          n_en = (m_since % RDIV == 0);
        end
      end else if (prs[1]) begin
        m_run = 1; m_since = 0; h_act = 0;
      end else if (prs[0]) begin
        n_en = 1; h_act = AR; h_since = 0;
      end else if (h_act && lvl[0]) begin
        h_since++;
        n_en = (h_since == HOLD) || (h_since > HOLD && (h_since - HOLD) % RDIV == 0);
      end else begin
        h_act = 0;
      end
      m_en = n_en; m_rst = n_rst; m_act = m_run;
      for (int b = 0; b < 3; b++) begin
        s = r2[b]; r2[b] = r1[b]; r1[b] = raw[b]; prs[b] = 0;
        run_len[b] = (s != lvl[b]) ? run_len[b] + 1 : 0;
        if (run_len[b] == DEB) begin
          lvl[b] = s; run_len[b] = 0; prs[b] = s;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, 1, 1);
    tick(0, 0, 0, 1);
    n_total++;
    if ({cnt_en, cnt_rst, run_active} !== 3'b000) begin
      $display("FAIL reset_outputs got=%b exp=000", {cnt_en, cnt_rst, run_active});
    end else n_pass++;
  endtask

  task automatic test_step_single();
    int first = -1, cnt = 0;
    tick(0, 0, 0, 1);
    for (int i = 1; i <= 40; i++) begin
      tick(i <= 20, 0, 0, 0);
      n_total++;
      if ({cnt_en, cnt_rst, run_active} !== {m_en, m_rst, m_act}) begin
        $display("FAIL step_cycle%0d got=%b exp=%b", i, {cnt_en, cnt_rst, run_active}, {m_en, m_rst, m_act});
      end else n_pass++;
      if (cnt_en) begin cnt++; if (first < 0) first = i; end
    end
    n_total++;
    if (first !== 7) $display("FAIL step_latency got=%0d exp=7", first);
    else n_pass++;
    n_total++;
    if (cnt !== (AR ? 2 : 1)) $display("FAIL step_count got=%0d exp=%0d", cnt, AR ? 2 : 1);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int cnt = 0;
    tick(0, 0, 0, 1);
    for (int i = 0; i < 45; i++) begin
      tick(i < 30 ? bit'((i / 2) % 2) : 1'b0, 0, 0, 0);
      if (cnt_en) cnt++;
    end
    n_total++;
    if (cnt !== 0) $display("FAIL bounce_count got=%0d exp=0", cnt);
    else n_pass++;
  endtask

  task automatic test_run_stop();
    int ens[$];
    int rise = -1, fall = -1;
    bit prev = 0;
    tick(0, 0, 0, 1);
    for (int i = 1; i <= 70; i++) begin
      tick(0, (i <= 12) || (i >= 41 && i <= 52), 0, 0);
      n_total++;
      if ({cnt_en, cnt_rst, run_active} !== {m_en, m_rst, m_act}) begin
        $display("FAIL run_cycle%0d got=%b exp=%b", i, {cnt_en, cnt_rst, run_active}, {m_en, m_rst, m_act});
      end else n_pass++;
      if (cnt_en) ens.push_back(i);
      if (run_active && !prev) rise = i;
      if (!run_active && prev) fall = i;
      prev = run_active;
    end
    n_total++;
    if (rise !== 7 || fall !== 47) $display("FAIL run_edges got=%0d,%0d exp=7,47", rise, fall);
    else n_pass++;
    n_total++;
    if (ens.size() !== 4) $display("FAIL run_pulse_count got=%0d exp=4", ens.size());
    else n_pass++;
    for (int k = 0; k < ens.size() && k < 4; k++) begin
      n_total++;
      if (ens[k] !== 15 + 8 * k) $display("FAIL run_pulse%0d got=%0d exp=%0d", k, ens[k], 15 + 8 * k);
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    int rsts = 0, en_after = 0, en_step = 0, rst_at = -1;
    tick(0, 0, 0, 1);
    for (int i = 1; i <= 20; i++) tick(0, i <= 10, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      tick(i <= 12, i <= 12, i <= 12, 0);
      if (cnt_rst) begin
        rsts++; rst_at = i;
        n_total++;
        if (cnt_en !== 1'b0 || run_active !== 1'b0) begin
          $display("FAIL prio_outs got=%b%b exp=00", cnt_en, run_active);
        end else n_pass++;
      end else if (rst_at > 0 && cnt_en) en_after++;
    end
    for (int i = 1; i <= 24; i++) begin
      tick(i <= 10, 0, 0, 0);
      if (cnt_en) en_step++;
    end
    n_total++;
    if (rsts !== 1 || rst_at !== 7) $display("FAIL prio_clear got=%0d@%0d exp=1@7", rsts, rst_at);
    else n_pass++;
    n_total++;
    if (en_after !== 0) $display("FAIL prio_no_en got=%0d exp=0", en_after);
    else n_pass++;
    n_total++;
    if (en_step !== 1) $display("FAIL prio_step got=%0d exp=1", en_step);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rise = -1, en_cnt = 0;
    tick(0, 0, 0, 1);
    for (int i = 1; i <= 21; i++) tick(0, 1, 0, 0);
    tick(0, 1, 0, 1);
    n_total++;
    if ({cnt_en, cnt_rst, run_active} !== 3'b000) begin
      $display("FAIL midrst_outputs got=%b exp=000", {cnt_en, cnt_rst, run_active});
    end else n_pass++;
    for (int i = 1; i <= 12; i++) begin
      tick(0, 1, 0, 0);
      if (cnt_en) en_cnt++;
      if (run_active && rise < 0) rise = i;
    end
    n_total++;
    if (rise !== 7 || en_cnt !== 0) $display("FAIL midrst_reenter got=%0d,%0d exp=7,0", rise, en_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int rem[3];
    bit val[3];
    for (int b = 0; b < 3; b++) begin rem[b] = 0; val[b] = 0; end
    tick(0, 0, 0, 1);
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          val[b] = bit'($urandom_range(0, 1));
          rem[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 30));
        end
        rem[b]--;
      end
      tick(val[0], val[1], val[2] && ($urandom_range(0, 2) == 0 || rem[2] > 0), $urandom_range(0, 199) == 0);
      n_total++;
      if ({cnt_en, cnt_rst, run_active} !== {m_en, m_rst, m_act}) begin
        $display("FAIL rand_cycle%0d got=%b exp=%b", i, {cnt_en, cnt_rst, run_active}, {m_en, m_rst, m_act});
      end else n_pass++;
      if (cnt_en && cnt_rst) begin
        n_total++;
        $display("FAIL rand_exclusive cycle%0d got=11 exp=not both", i);
      end
    end
  endtask

`ifdef GRAY_CTRL_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int ens[$];
    int exp_t[7] = '{7, 23, 31, 39, 47, 55, 63};
    tick(0, 0, 0, 1);
    for (int i = 1; i <= 80; i++) begin
      tick(i <= 60, 0, 0, 0);
      if (cnt_en) ens.push_back(i);
    end
    n_total++;
    if (ens.size() !== 7) $display("FAIL auto_count got=%0d exp=7", ens.size());
    else n_pass++;
    for (int k = 0; k < ens.size() && k < 7; k++) begin
      n_total++;
      if (ens[k] !== exp_t[k]) $display("FAIL auto_pulse%0d got=%0d exp=%0d", k, ens[k], exp_t[k]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_step_single();
    test_bounce();
    test_run_stop();
    test_priority();
    test_reset_mid();
`ifdef GRAY_CTRL_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
